// File: rtl/star.sv
// STAR softmax front-end: fetches one vector, sequences the CAMSUB / FINDSUB / EXP
// phases and accumulates exponents. Define STAR_SUM_MV_EN to build the o_sum_MV histogram.
module star #(
  parameter int N_ELEM    = 16,
  parameter int ADDR_BASE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic signed [7:0] data,
  output logic              data_req,
  output logic [8:0]        data_addr,
  input  logic [63:0]       i_xi_MV,
  output logic              CAMSUB_req,
  output logic signed [7:0] xi,
  output logic [63:0]       o_xmax_MV,
  output logic [63:0]       o_xi_MV,
  output logic              FindSub_req,
  input  logic [63:0]       i_sub_MV,
  output logic              EXP_req,
  output logic [7:0]        exp,
  output logic [7:0]        Sum_exp,
  output logic [63:0]       o_sub_MV,
  output logic [2:0]        o_sum_MV [0:63],
  output logic              finish
);

  localparam int CW = $clog2(N_ELEM + 1);
  localparam int IW = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
  localparam logic [CW-1:0] NE   = CW'(N_ELEM);
  localparam logic [CW-1:0] LAST = CW'(N_ELEM - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CAMSUB, S_FINDSUB, S_EXP, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic signed [7:0] buf_q [N_ELEM];
  logic signed [7:0] xi_q;
  logic [63:0]       xi_mv_q, xmax_q, sub_mv_q;
  logic [7:0]        exp_q, sum_q;
  logic              finish_q;
  logic              last;
  logic              sub_ok;
  logic [5:0]        sub_idx;
  logic [7:0]        sub_exp;

  // floor(15 * 2^(d/2)) for d = k - 50; zero outside -7..0
  function automatic logic [7:0] exp_lut(input logic [5:0] k);
    case (k)
      6'd50:        exp_lut = 8'd15;
      6'd49:        exp_lut = 8'd10;
      6'd48:        exp_lut = 8'd7;
      6'd47:        exp_lut = 8'd5;
      6'd46:        exp_lut = 8'd3;
      6'd45:        exp_lut = 8'd2;
      6'd44, 6'd43: exp_lut = 8'd1;
      default:      exp_lut = 8'd0;
    endcase
  endfunction

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    sat_add8 = s[8] ? 8'hFF : s[7:0];
  endfunction

  function automatic logic [5:0] onehot_idx(input logic [63:0] v);
    onehot_idx = '0;
    for (int i = 0; i < 64; i++)
      if (v[i]) onehot_idx = 6'(i);
  endfunction

  function automatic logic [63:0] msb_only(input logic [63:0] v);
    msb_only = '0;
    for (int i = 0; i < 64; i++)
      if (v[i]) begin
        msb_only    = '0;
        msb_only[i] = 1'b1;
      end
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    data_req    = 1'b0;
    CAMSUB_req  = 1'b0;
    FindSub_req = 1'b0;
    EXP_req     = 1'b0;
    last        = (cnt_q == LAST);
    case (state_q)
      S_IDLE: begin
        state_d = S_LOAD;
        cnt_d   = '0;
      end
      // one extra cycle so the last requested element can be captured
      S_LOAD: begin
        data_req = (cnt_q < NE);
        if (cnt_q == NE) begin
          state_d = S_CAMSUB;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_CAMSUB: begin
        CAMSUB_req = 1'b1;
        if (last) begin
          state_d = S_FINDSUB;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_FINDSUB: begin
        FindSub_req = 1'b1;
        if (last) begin
          state_d = S_EXP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_EXP: begin
        EXP_req = 1'b1;
        if (last) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  assign data_addr = data_req ? (9'(ADDR_BASE) + 9'(cnt_q)) : 9'd0;

  // Unknown, empty or multi-hot difference vectors carry no information
  always_comb begin
    sub_ok  = !$isunknown(i_sub_MV) && $onehot(i_sub_MV);
    sub_idx = onehot_idx(i_sub_MV);
    sub_exp = exp_lut(sub_idx);
  end

  always_ff @(posedge clk) begin
    if (state_q == S_LOAD && cnt_q != '0)
      buf_q[IW'(cnt_q - 1'b1)] <= data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      xi_q     <= '0;
      xi_mv_q  <= '0;
      xmax_q   <= '0;
      exp_q    <= '0;
      sum_q    <= '0;
      sub_mv_q <= '0;
      finish_q <= 1'b0;
    end else begin
      case (state_q)
        S_LOAD: begin
          // preload the first element so xi is valid in the first CAMSUB cycle
          if (cnt_q == NE)
            xi_q <= (N_ELEM == 1) ? data : buf_q[0];
        end
        S_CAMSUB: begin
          xi_mv_q <= xi_mv_q | i_xi_MV;
          if (last)
            xmax_q <= msb_only(xi_mv_q | i_xi_MV);
          else
            xi_q <= buf_q[IW'(cnt_q + 1'b1)];
        end
        S_EXP: begin
          if (sub_ok) begin
            exp_q    <= sub_exp;
            sum_q    <= sat_add8(sum_q, sub_exp);
            sub_mv_q <= sub_mv_q | i_sub_MV;
          end else begin
            exp_q <= '0;
          end
        end
        S_DONE:  finish_q <= 1'b1;
        default: ;
      endcase
    end
  end

`ifdef STAR_SUM_MV_EN
  logic [2:0] hist_q [0:63];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) hist_q[i] <= '0;
    end else if (state_q == S_EXP && sub_ok && hist_q[sub_idx] != 3'd7) begin
      hist_q[sub_idx] <= hist_q[sub_idx] + 3'd1;
    end
  end

  always_comb begin
    for (int i = 0; i < 64; i++) o_sum_MV[i] = hist_q[i];
  end
`else
  always_comb begin
    for (int i = 0; i < 64; i++) o_sum_MV[i] = 3'd0;
  end
`endif

  assign xi        = xi_q;
  assign o_xi_MV   = xi_mv_q;
  assign o_xmax_MV = xmax_q;
  assign exp       = exp_q;
  assign Sum_exp   = sum_q;
  assign o_sub_MV  = sub_mv_q;
  assign finish    = finish_q;

endmodule

// File: tb/tb_star.sv
// Bench for star: memory and ideal CAM models, a per-cycle exponent scoreboard and
// a table of whole-vector scenarios with their final results.
module tb_star;

  logic              clk = 1'b0;
  logic              reset;
  logic signed [7:0] data;
  logic              data_req;
  logic [8:0]        data_addr;
  logic [63:0]       i_xi_MV;
  logic              CAMSUB_req;
  logic signed [7:0] xi;
  logic [63:0]       o_xmax_MV;
  logic [63:0]       o_xi_MV;
  logic              FindSub_req;
  logic [63:0]       i_sub_MV;
  logic              EXP_req;
  logic [7:0]        exp_o;
  logic [7:0]        Sum_exp;
  logic [63:0]       o_sub_MV;
  logic [2:0]        o_sum_MV [0:63];
  logic              finish;

  always #5 clk = ~clk;

  star #(.N_ELEM(16), .ADDR_BASE(0)) dut (
    .clk(clk), .reset(reset), .data(data), .data_req(data_req), .data_addr(data_addr),
    .i_xi_MV(i_xi_MV), .CAMSUB_req(CAMSUB_req), .xi(xi), .o_xmax_MV(o_xmax_MV),
    .o_xi_MV(o_xi_MV), .FindSub_req(FindSub_req), .i_sub_MV(i_sub_MV), .EXP_req(EXP_req),
    .exp(exp_o), .Sum_exp(Sum_exp), .o_sub_MV(o_sub_MV), .o_sum_MV(o_sum_MV), .finish(finish)
  );

  typedef struct {
    logic [15:0][7:0] vin;
    int               z_cyc;
    int               mh_cyc;
    logic [63:0]      xi_mv;
    logic [63:0]      xmax;
    int               sum;
    logic [63:0]      sub_mv;
    int               h50;
    int               h27;
  } vec_t;

  typedef struct {
    int e;
    int s;
  } exp_t;

  vec_t              tbl [4];
  logic signed [7:0] mem [0:15];
  int                z_cyc, mh_cyc, xmax_v;
  int                exp_idx, cam_idx, m_sum;
  logic [63:0]       m_sub;
  int                m_hist [64];
  exp_t              sbq [$];
  int                n_chk, n_fail;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [63:0] hot(input int i);
    logic [63:0] v;
    v = '0;
    if (i >= 0 && i < 64) v[i] = 1'b1;
    return v;
  endfunction

  function automatic int lut_model(input int d);
    if (d > 0 || d <= -8) return 0;
    return int'($floor(15.0 * (2.0 ** (real'(d) / 2.0))));
  endfunction

  task automatic model_clear();
    sbq.delete();
    exp_idx = 0;
    cam_idx = 0;
    m_sum   = 0;
    m_sub   = '0;
    for (int i = 0; i < 64; i++) m_hist[i] = 0;
  endtask

  // Memory + ideal CAM models; expected exp/Sum_exp queued as each sample is driven
  task automatic drive_loop();
    logic [63:0] s;
    exp_t        t;
    int          k;
    forever begin
      @(posedge clk);
      if (data_req) data <= mem[data_addr[3:0]];
      if (reset) model_clear();
      @(negedge clk);
      if (sbq.size() > 0) begin
        t = sbq.pop_front();
        chk("exp", 64'(exp_o), 64'(t.e));
        chk("Sum_exp", 64'(Sum_exp), 64'(t.s));
      end
      if (data_req | CAMSUB_req | FindSub_req | EXP_req)
        chk("req_onehot", 64'($countones({data_req, CAMSUB_req, FindSub_req, EXP_req})), 64'd1);
      if (CAMSUB_req && cam_idx < 16) begin
        chk("xi", 64'(xi), 64'(mem[cam_idx]));
        i_xi_MV = hot(int'(xi) + 20);
        cam_idx++;
      end else begin
        i_xi_MV = '0;
      end
      if (EXP_req && exp_idx < 16) begin
        if (exp_idx == z_cyc) s = '0;
        else if (exp_idx == mh_cyc) s = 64'h3;
        else s = hot(int'(mem[exp_idx]) - xmax_v + 50);
        i_sub_MV = s;
        t.e = 0;
        if ($onehot(s)) begin
          k = 0;
          for (int i = 0; i < 64; i++) if (s[i]) k = i;
          t.e = lut_model(k - 50);
          m_sum = (m_sum + t.e > 255) ? 255 : m_sum + t.e;
          m_sub = m_sub | s;
          if (m_hist[k] < 7) m_hist[k]++;
        end
        t.s = m_sum;
        sbq.push_back(t);
        exp_idx++;
      end else begin
        i_sub_MV = '0;
      end
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_data_req"}, 64'(data_req), 64'd0);
    chk({tag, "_data_addr"}, 64'(data_addr), 64'd0);
    chk({tag, "_CAMSUB_req"}, 64'(CAMSUB_req), 64'd0);
    chk({tag, "_FindSub_req"}, 64'(FindSub_req), 64'd0);
    chk({tag, "_EXP_req"}, 64'(EXP_req), 64'd0);
    chk({tag, "_xi"}, 64'(xi), 64'd0);
    chk({tag, "_xi_MV"}, o_xi_MV, 64'd0);
    chk({tag, "_xmax_MV"}, o_xmax_MV, 64'd0);
    chk({tag, "_sub_MV"}, o_sub_MV, 64'd0);
    chk({tag, "_exp"}, 64'(exp_o), 64'd0);
    chk({tag, "_Sum_exp"}, 64'(Sum_exp), 64'd0);
    chk({tag, "_finish"}, 64'(finish), 64'd0);
    chk({tag, "_sum_MV50"}, 64'(o_sum_MV[50]), 64'd0);
  endtask

  task automatic load_vec(input int v);
    xmax_v = -128;
    for (int k = 0; k < 16; k++) begin
      mem[k] = tbl[v].vin[k];
      if (int'(mem[k]) > xmax_v) xmax_v = int'(mem[k]);
    end
    z_cyc  = tbl[v].z_cyc;
    mh_cyc = tbl[v].mh_cyc;
  endtask

  // Release reset at a falling edge and count rising edges until finish shows
  task automatic release_and_wait(input string tag);
    int n;
    reset = 1'b0;
    n = 0;
    while (!finish && n < 200) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk({tag, "_latency"}, 64'(n), 64'd67);
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    reset = 1'b1;
    data = '0;
    i_xi_MV = '0;
    i_sub_MV = '0;
    z_cyc = -1;
    mh_cyc = -1;
    xmax_v = 0;
    for (int k = 0; k < 16; k++) mem[k] = '0;
    model_clear();

    tbl[0] = '{vin: '0, z_cyc: -1, mh_cyc: -1, xi_mv: 64'h0000_0000_0010_0000,
               xmax: 64'h0000_0000_0010_0000, sum: 240, sub_mv: 64'h0004_0000_0000_0000,
               h50: 7, h27: 0};
    tbl[1] = '{vin: '0, z_cyc: -1, mh_cyc: -1, xi_mv: 64'h0000_000F_FFF0_0000,
               xmax: 64'h0000_0008_0000_0000, sum: 44, sub_mv: 64'h0007_FFF8_0000_0000,
               h50: 1, h27: 0};
    tbl[2] = '{vin: '0, z_cyc: -1, mh_cyc: -1, xi_mv: 64'h0000_0000_0080_0001,
               xmax: 64'h0000_0000_0080_0000, sum: 120, sub_mv: 64'h0004_0000_0800_0000,
               h50: 7, h27: 7};
    tbl[3] = '{vin: '0, z_cyc: 3, mh_cyc: 7, xi_mv: 64'h0000_0000_0010_0000,
               xmax: 64'h0000_0000_0010_0000, sum: 210, sub_mv: 64'h0004_0000_0000_0000,
               h50: 7, h27: 0};
    for (int k = 0; k < 16; k++) begin
      tbl[1].vin[k] = 8'(k);
      tbl[2].vin[k] = (k % 2 == 0) ? 8'hEC : 8'h03;
    end

    fork
      drive_loop();
    join_none

    repeat (3) @(negedge clk);
    check_reset_state("rst");

    for (int v = 0; v < 4; v++) begin
      reset = 1'b1;
      load_vec(v);
      repeat (2) @(negedge clk);
      release_and_wait($sformatf("v%0d", v));
      chk($sformatf("v%0d_xi_MV", v), o_xi_MV, tbl[v].xi_mv);
      chk($sformatf("v%0d_xmax_MV", v), o_xmax_MV, tbl[v].xmax);
      chk($sformatf("v%0d_Sum_exp", v), 64'(Sum_exp), 64'(tbl[v].sum));
      chk($sformatf("v%0d_sub_MV", v), o_sub_MV, tbl[v].sub_mv);
`ifdef STAR_SUM_MV_EN
      chk($sformatf("v%0d_sum_MV50", v), 64'(o_sum_MV[50]), 64'(tbl[v].h50));
      chk($sformatf("v%0d_sum_MV27", v), 64'(o_sum_MV[27]), 64'(tbl[v].h27));
      for (int i = 0; i < 64; i++)
        chk($sformatf("v%0d_sum_MV[%0d]", v, i), 64'(o_sum_MV[i]), 64'(m_hist[i]));
`else
      for (int i = 0; i < 64; i++)
        chk($sformatf("v%0d_sum_MV[%0d]", v, i), 64'(o_sum_MV[i]), 64'd0);
`endif
      repeat (3) @(negedge clk);
      chk($sformatf("v%0d_finish_hold", v), 64'(finish), 64'd1);
      chk($sformatf("v%0d_Sum_hold", v), 64'(Sum_exp), 64'(tbl[v].sum));
      chk($sformatf("v%0d_req_idle", v),
          64'({data_req, CAMSUB_req, FindSub_req, EXP_req}), 64'd0);
    end

    // Reset in the middle of EXP, then a full restart
    reset = 1'b1;
    load_vec(0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    begin
      int w;
      w = 0;
      while (!EXP_req && w < 200) begin
        @(negedge clk);
        w++;
      end
      chk("midexp_reach_exp", 64'(EXP_req), 64'd1);
    end
    repeat (5) @(negedge clk);
    chk("midexp_partial_sum", 64'(Sum_exp), 64'd75);
    reset = 1'b1;
    @(negedge clk);
    check_reset_state("midexp");
    release_and_wait("restart");
    chk("restart_Sum_exp", 64'(Sum_exp), 64'd240);
    chk("restart_xmax_MV", o_xmax_MV, 64'h0000_0000_0010_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
